// File: rtl/core_pipe_pkg.sv
// Shared pipeline-stage types: boundary state encoding, NOP instruction and stage bundle layouts.
package core_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
    } id_ex_bundle_t;

    localparam int ID_EX_W = $bits(id_ex_bundle_t);

    function automatic logic [1:0] occupancy_of(input pipe_state_t s);
        case (s)
            HALF:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter for perf monitoring.
// Latency: count reflects inc/clr one cycle later.
// Backpressure: none; clr wins over inc, holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline-boundary register carrying an opaque payload under valid/ready, with flush bubbles.
// Latency: accepted beat appears on out_data the next cycle, strict FIFO order.
// Backpressure: SKID_EN=1 holds 2 beats behind a registered in_ready; SKID_EN=0 holds 1, in_ready combinational.
module pipe_skid_stage
    import core_pipe_pkg::*;
#(
    parameter int              DATA_W  = 160,
    parameter bit              SKID_EN = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int              CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state_q;
    logic [DATA_W-1:0] main_q;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = occupancy_of(state_q);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    generate
        if (SKID_EN) begin : g_skid
            pipe_state_t       state_d;
            logic [DATA_W-1:0] main_d;
            logic [DATA_W-1:0] skid_q;
            logic [DATA_W-1:0] skid_d;
            logic              rdy_q;

            // main is the head beat; skid only ever holds the second beat while FULL
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                state_d = HALF;
                                main_d  = in_data;
                            end
                        end
                        HALF: begin
                            if (in_fire && !out_fire) begin
                                state_d = FULL;
                                skid_d  = in_data;
                            end else if (in_fire && out_fire) begin
                                main_d  = in_data;
                            end else if (out_fire) begin
                                state_d = EMPTY;
                                main_d  = BUBBLE;
                            end
                        end
                        FULL: begin
                            if (out_fire) begin
                                state_d = HALF;
                                main_d  = skid_q;
                                skid_d  = BUBBLE;
                            end
                        end
                        default: begin
                            state_d = EMPTY;
                            main_d  = BUBBLE;
                            skid_d  = BUBBLE;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= EMPTY;
                    main_q  <= BUBBLE;
                    skid_q  <= BUBBLE;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                    rdy_q   <= (state_d != FULL);
                end
            end

            assign in_ready = rdy_q;
        end else begin : g_single
            pipe_state_t       state_d;
            logic [DATA_W-1:0] main_d;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                if (flush) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end else if (in_fire) begin
                    state_d = HALF;
                    main_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= EMPTY;
                    main_q  <= BUBBLE;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                end
            end

            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready),
        .clr   (clr_stats),
        .count (stall_cnt)
    );

endmodule
